ddr_cmd_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of the DdrCtl1 instruction port.

---
 rtl/ddr_cmd_arbiter_if.sv | 41 ++++
 rtl/ddr_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr_cmd_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_arbiter_if.sv
// Purpose: bundles the two requester ports and the DdrCtl1 instruction port
//          of ddr_cmd_arbiter into one interface.
// Signals:
//   req0_inst/req0_valid -> arbiter,  req0_ack/req0_done <- arbiter
//   req1_inst/req1_valid -> arbiter,  req1_ack/req1_done <- arbiter
//   ctl_inst/ctl_inst_en <- arbiter (to DdrCtl1), ctl_ready/ctl_page -> arbiter
//   page_o, owner, busy, error <- arbiter status
// Modports: slave = arbiter side, master = requesters/controller side.
interface ddr_cmd_arbiter_if #(
  parameter int unsigned INST_W = 12,
  parameter int unsigned PAGE_W = 32
);
  logic [INST_W-1:0] req0_inst;
  logic              req0_valid;
  logic              req0_ack;
  logic              req0_done;
  logic [INST_W-1:0] req1_inst;
  logic              req1_valid;
  logic              req1_ack;
  logic              req1_done;
  logic [INST_W-1:0] ctl_inst;
  logic              ctl_inst_en;
  logic              ctl_ready;
  logic [PAGE_W-1:0] ctl_page;
  logic [PAGE_W-1:0] page_o;
  logic              owner;
  logic              busy;
  logic              error;

  modport slave (
    input  req0_inst, req0_valid, req1_inst, req1_valid, ctl_ready, ctl_page,
    output req0_ack, req0_done, req1_ack, req1_done, ctl_inst, ctl_inst_en,
           page_o, owner, busy, error
  );

  modport master (
    output req0_inst, req0_valid, req1_inst, req1_valid, ctl_ready, ctl_page,
    input  req0_ack, req0_done, req1_ack, req1_done, ctl_inst, ctl_inst_en,
           page_o, owner, busy, error
  );
endinterface

// File: rtl/ddr_cmd_arbiter.sv
// Purpose: two-requester round-robin arbiter in front of the DdrCtl1
//          instruction port. Issues one instruction at a time, waits for the
//          controller to return to ready (or time out), then hands the page
//          word and a done pulse back to the owning requester.
// Ports:
//   clock  - rising-edge clock shared with DdrCtl1
//   reset  - synchronous, active-high
//   bus    - ddr_cmd_arbiter_if.slave (requester handshakes, controller port,
//            page_o/owner/busy/error status); all outputs registered.
module ddr_cmd_arbiter #(
  parameter int unsigned INST_W  = 12,
  parameter int unsigned PAGE_W  = 32,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  ddr_cmd_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic                en_q, en_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          done_q, done_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                grant_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    error_d = error_q;
    inst_d  = inst_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    en_d    = 1'b0;
    ack_d   = 2'b00;
    done_d  = 2'b00;

    // A lone requester wins outright; a tie goes to the round-robin pointer.
    grant_c = prio_q;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant_c = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      grant_c = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Only arbitrate once the controller is idle, so a command left in
        // flight across a reset can never overlap a new one.
        if (bus.ctl_ready && (bus.req0_valid || bus.req1_valid)) begin
          owner_d = grant_c;
          inst_d  = grant_c ? bus.req1_inst : bus.req0_inst;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        en_d    = 1'b1;
        ack_d   = owner_q ? 2'b10 : 2'b01;
        cnt_d   = CNT_W'(SETTLE);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // ctl_ready may still show the pre-issue idle state here; ignore it.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ctl_ready) begin
          page_d  = bus.ctl_page;
          done_d  = owner_q ? 2'b10 : 2'b01;
          prio_d  = ~owner_q;
          state_d = S_IDLE;
        end else if (tmr_q == TMR_W'(TIMEOUT)) begin
          // Abort: release the requester, keep the previous page word.
          error_d = 1'b1;
          done_d  = owner_q ? 2'b10 : 2'b01;
          prio_d  = ~owner_q;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      inst_q  <= '0;
      page_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.req0_ack    = ack_q[0];
  assign bus.req1_ack    = ack_q[1];
  assign bus.req0_done   = done_q[0];
  assign bus.req1_done   = done_q[1];
  assign bus.ctl_inst    = inst_q;
  assign bus.ctl_inst_en = en_q;
  assign bus.page_o      = page_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Purpose: directed self-checking bench for ddr_cmd_arbiter (SETTLE=2,
//          TIMEOUT=255). The bench plays both requesters and DdrCtl1.
module tb_ddr_cmd_arbiter;

  localparam int unsigned INST_W = 12;
  localparam int unsigned PAGE_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp  = 0;
  int n_err  = 0;
  int en_cnt = 0;
  int viol   = 0;
  int        grants[$];
  logic [INST_W-1:0] insts[$];

  ddr_cmd_arbiter_if #(.INST_W(INST_W), .PAGE_W(PAGE_W)) bus ();

  ddr_cmd_arbiter #(
    .INST_W (INST_W),
    .PAGE_W (PAGE_W),
    .SETTLE (2),
    .TIMEOUT(255)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until any done pulse is visible or the budget runs out.
  task automatic wait_done(input int bound, output int n, output logic seen);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < bound) begin
      tick();
      n++;
      if (bus.req0_done || bus.req1_done) seen = 1'b1;
    end
  endtask

  // Mid-cycle monitor: grant order and handshake invariants.
  always @(negedge clk) begin
    if (bus.ctl_inst_en === 1'b1) begin
      en_cnt++;
      if (!(bus.req0_ack || bus.req1_ack)) viol++;
    end
    if ((bus.req0_ack === 1'b1 || bus.req1_ack === 1'b1) && bus.ctl_inst_en !== 1'b1) viol++;
    if ((bus.req0_ack === 1'b1 || bus.req1_ack === 1'b1) &&
        (bus.req0_done === 1'b1 || bus.req1_done === 1'b1)) viol++;
    if ((bus.req0_ack === 1'b1 && bus.req1_ack === 1'b1) ||
        (bus.req0_done === 1'b1 && bus.req1_done === 1'b1)) viol++;
    if (bus.req0_ack === 1'b1) begin grants.push_back(0); insts.push_back(bus.ctl_inst); end
    if (bus.req1_ack === 1'b1) begin grants.push_back(1); insts.push_back(bus.ctl_inst); end
  end

  function automatic logic [63:0] out_vec();
    return 64'({bus.busy, bus.owner, bus.error, bus.ctl_inst_en, bus.req0_ack,
                bus.req1_ack, bus.req0_done, bus.req1_done, bus.ctl_inst, bus.page_o});
  endfunction

  initial begin
    int   n;
    int   ndone;
    int   en0;
    logic seen;

    bus.req0_inst  = '0;
    bus.req0_valid = 1'b0;
    bus.req1_inst  = '0;
    bus.req1_valid = 1'b0;
    bus.ctl_ready  = 1'b1;
    bus.ctl_page   = '0;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_eq("reset_outs", out_vec(), 64'd0);

    // 1: single request from req0, grant visible after 1 edge, issue after 2
    bus.req0_inst  = 12'h0A5;
    bus.req0_valid = 1'b1;
    tick();
    chk_eq("t1_busy",  64'(bus.busy), 64'd1);
    chk_eq("t1_owner", 64'(bus.owner), 64'd0);
    chk_eq("t1_inst",  64'(bus.ctl_inst), 64'h0A5);
    chk_eq("t1_en_early", 64'(bus.ctl_inst_en), 64'd0);
    tick();
    chk_eq("t1_en",   64'(bus.ctl_inst_en), 64'd1);
    chk_eq("t1_ack0", 64'(bus.req0_ack), 64'd1);
    chk_eq("t1_ack1", 64'(bus.req1_ack), 64'd0);
    bus.req0_valid = 1'b0;
    bus.req0_inst  = 12'hFFF;

    // 2: controller busy 10 cycles, then ready with the page word
    bus.ctl_ready = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.req0_done || bus.req1_done) ndone++;
    end
    chk_eq("t2_no_early_done", 64'(ndone), 64'd0);
    chk_eq("t2_inst_held", 64'(bus.ctl_inst), 64'h0A5);
    bus.ctl_page  = 32'hDEADBEEF;
    bus.ctl_ready = 1'b1;
    tick();
    chk_eq("t2_done0", 64'(bus.req0_done), 64'd1);
    chk_eq("t2_page",  64'(bus.page_o), 64'hDEADBEEF);
    tick();
    chk_eq("t2_done_pulse", 64'(bus.req0_done), 64'd0);
    chk_eq("t2_busy", 64'(bus.busy), 64'd0);

    // 4: req1 while controller not ready -> nothing issued until ready
    en0 = en_cnt;
    bus.ctl_ready  = 1'b0;
    bus.req1_inst  = 12'h3C3;
    bus.req1_valid = 1'b1;
    repeat (6) tick();
    chk_eq("t4_no_issue", 64'(en_cnt - en0), 64'd0);
    chk_eq("t4_idle", 64'(bus.busy), 64'd0);
    bus.ctl_ready = 1'b1;
    tick();
    chk_eq("t4_owner", 64'(bus.owner), 64'd1);
    tick();
    chk_eq("t4_ack1", 64'(bus.req1_ack), 64'd1);
    chk_eq("t4_inst", 64'(bus.ctl_inst), 64'h3C3);
    bus.req1_valid = 1'b0;
    wait_done(20, n, seen);
    chk_eq("t4_done1", 64'(seen && bus.req1_done), 64'd1);
    tick();

    // 3: both valid continuously; pointer is back at 0 after req1 completed
    grants.delete();
    insts.delete();
    en0 = en_cnt;
    bus.req0_inst  = 12'h111;
    bus.req1_inst  = 12'h222;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    ndone = 0;
    for (int c = 0; c < 100 && ndone < 4; c++) begin
      tick();
      if (bus.req0_done || bus.req1_done) ndone++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk_eq("t3_dones", 64'(ndone), 64'd4);
    tick(); tick();
    chk_eq("t3_grants", 64'(grants.size()), 64'd4);
    chk_eq("t3_en_pulses", 64'(en_cnt - en0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) begin
        chk_eq($sformatf("t3_order%0d", i), 64'(grants[i]), 64'(i % 2));
        chk_eq($sformatf("t3_inst%0d", i), 64'(insts[i]), (i % 2 == 1) ? 64'h222 : 64'h111);
      end
    end

    // 5: ready stuck low -> abort. Edges after the issue cycle: 2 in SETTLE,
    //    then WAIT holds timer 0..255 (256 cycles), abort edge -> done is
    //    visible 258 ticks after the ctl_inst_en cycle.
    bus.req0_inst  = 12'h5A5;
    bus.req0_valid = 1'b1;
    tick(); tick();
    chk_eq("t5_ack0", 64'(bus.req0_ack), 64'd1);
    bus.req0_valid = 1'b0;
    bus.ctl_ready  = 1'b0;
    bus.ctl_page   = 32'h12345678;
    wait_done(400, n, seen);
    chk_eq("t5_seen", 64'(seen && bus.req0_done), 64'd1);
    chk_eq("t5_latency", 64'(n), 64'd258);
    chk_eq("t5_error", 64'(bus.error), 64'd1);
    chk_eq("t5_page_kept", 64'(bus.page_o), 64'hDEADBEEF);
    bus.ctl_ready  = 1'b1;
    bus.req1_inst  = 12'h0F0;
    bus.req1_valid = 1'b1;
    tick(); tick();
    chk_eq("t5_next_ack1", 64'(bus.req1_ack), 64'd1);
    bus.req1_valid = 1'b0;
    wait_done(20, n, seen);
    chk_eq("t5_next_done1", 64'(seen && bus.req1_done), 64'd1);
    chk_eq("t5_error_sticky", 64'(bus.error), 64'd1);
    chk_eq("t5_page_new", 64'(bus.page_o), 64'h12345678);
    tick();

    // 6: reset while in WAIT, then hold off new request until ready
    bus.req0_inst  = 12'h777;
    bus.req0_valid = 1'b1;
    tick(); tick();
    bus.req0_valid = 1'b0;
    bus.ctl_ready  = 1'b0;
    repeat (4) tick();
    chk_eq("t6_busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    chk_eq("t6_reset_outs", out_vec(), 64'd0);
    rst = 1'b0;
    en0 = en_cnt;
    bus.req1_inst  = 12'h456;
    bus.req1_valid = 1'b1;
    repeat (5) tick();
    chk_eq("t6_no_issue", 64'(en_cnt - en0), 64'd0);
    bus.ctl_ready = 1'b1;
    tick(); tick();
    chk_eq("t6_ack1", 64'(bus.req1_ack), 64'd1);
    chk_eq("t6_inst", 64'(bus.ctl_inst), 64'h456);
    bus.req1_valid = 1'b0;
    wait_done(20, n, seen);
    chk_eq("t6_done1", 64'(seen && bus.req1_done), 64'd1);
    tick();

    chk_eq("invariants", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
